muldiv_sequencer: RTL and testbench

Multi-cycle controller for MULT/DIV in the pipelined MIPS core. Accepts a signed multiply or divide from the EX stage, sequences a 32-iteration shift-add multiplier / restoring divider, owns the HI/LO registers, and stalls the pipeline when MFHI/MFLO or a new MULT/DIV arrives while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_core.sv | 76 +++++++
 rtl/muldiv_sequencer.sv | 129 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer and its iterative datapath.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_MULT = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } stateT;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: one shift-add multiply step or one restoring-divide step per cycle.
// MULDIV_EARLY_OUT_EN: report multiply completion once the remaining multiplier runs out of set bits.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               isMult,
  input  logic [WIDTH-1:0]   magA,
  input  logic [WIDTH-1:0]   magB,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               multDone
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   remReg;
  logic [WIDTH-1:0]   dvdReg;
  logic [WIDTH-1:0]   divisor;

  // One extra bit so a divisor of magnitude 2^(WIDTH-1) still compares correctly.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           noBorrow;

  assign shifted  = {remReg, dvdReg[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign noBorrow = ~trial[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      remReg  <= '0;
      dvdReg  <= '0;
      divisor <= '0;
    end else if (load) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, magA};
      mplier  <= magB;
      remReg  <= '0;
      dvdReg  <= magA;
      divisor <= magB;
    end else if (step) begin
      if (isMult) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else begin
        remReg <= noBorrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvdReg <= {dvdReg[WIDTH-2:0], noBorrow};
      end
    end
  end

  assign product   = acc;
  assign quotient  = dvdReg;
  assign remainder = remReg;

`ifdef MULDIV_EARLY_OUT_EN
  assign multDone = (mplier[WIDTH-1:1] == '0);
`else
  assign multDone = 1'b0;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/DIV controller: accepts signed ops, runs the iterative core, applies signs and owns HI/LO.
// MULDIV_EARLY_OUT_EN (see muldiv_core) lets short multiplies leave CALC early.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             read_hi,
  input  logic             read_lo,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  stateT state;
  stateT nextState;

  logic [CW-1:0]      iterCount;
  logic               load;
  logic               step;
  logic               lastIter;
  logic               opIsMult;
  logic               negResult;
  logic               negRem;
  logic               divZeroOp;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               multDone;

  assign magA = op_a[WIDTH-1] ? -op_a : op_a;
  assign magB = op_b[WIDTH-1] ? -op_b : op_b;

  assign lastIter = (iterCount == LAST_ITER) || (opIsMult && multDone);

  muldiv_core #(.WIDTH(WIDTH)) core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .isMult    (opIsMult),
    .magA      (magA),
    .magB      (magB),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .multDone  (multDone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Starts are only taken in IDLE; a stalled issue is simply re-presented until then.
  always_comb begin
    nextState = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = (state != IDLE);
    stall     = busy & (read_hi | read_lo | start_mult | start_div);
    case (state)
      IDLE: begin
        if (start_mult || start_div) begin
          load      = 1'b1;
          nextState = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (lastIter) begin
          nextState = SIGN;
        end
      end
      SIGN:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // MULT wins a simultaneous issue; a zero divisor is flagged at accept and forces LO to all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      iterCount <= '0;
      opIsMult  <= 1'b0;
      negResult <= 1'b0;
      negRem    <= 1'b0;
      divZeroOp <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (load) begin
        iterCount <= '0;
        opIsMult  <= start_mult;
        negResult <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        negRem    <= op_a[WIDTH-1];
        divZeroOp <= ~start_mult & (op_b == '0);
        div_zero  <= ~start_mult & (op_b == '0);
      end else if (step) begin
        iterCount <= iterCount + 1'b1;
      end
      if (state == SIGN) begin
        if (opIsMult) begin
          {hi, lo} <= negResult ? -product : product;
        end else begin
          hi <= negRem ? -remainder : remainder;
          lo <= divZeroOp ? '1 : (negResult ? -quotient : quotient);
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random and directed MULT/DIV against an arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        read_hi;
  logic        read_lo;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .read_hi    (read_hi),
    .read_lo    (read_lo),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo),
    .div_zero   (div_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } ExpEntry;

  ExpEntry expQ[$];
  int      total = 0;
  int      bad = 0;
  bit      monPrevBusy;
  int      monCycles;
  ExpEntry monEntry;

  // Reference results from plain signed arithmetic; latency is busy cycles (iterations + SIGN).
  function automatic ExpEntry model(input bit isMult, input logic [31:0] a, input logic [31:0] b);
    ExpEntry     e;
    longint      p;
    int          q;
    int          r;
    logic [31:0] mag;
    int          n;
    e.dz  = 1'b0;
    e.lat = 33;
    if (isMult) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      e.hi = p[63:32];
      e.lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      mag = b[31] ? (32'd0 - b) : b;
      n   = 0;
      while (mag != 0) begin
        n++;
        mag = mag >> 1;
      end
      if (n == 0) n = 1;
      e.lat = n + 1;
`endif
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = 32'd0;
      e.lo = 32'h8000_0000;
    end else begin
      q    = $signed(a) / $signed(b);
      r    = $signed(a) % $signed(b);
      e.hi = q[31:0] == q[31:0] ? r : r;
      e.lo = q;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: each busy->idle transition retires the oldest expected result.
  initial begin
    monPrevBusy = 1'b0;
    monCycles   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        monPrevBusy = 1'b0;
        monCycles   = 0;
      end else if (busy) begin
        monCycles++;
        monPrevBusy = 1'b1;
      end else if (monPrevBusy) begin
        monPrevBusy = 1'b0;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedDone: got completion expected none");
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("hi", 64'(hi), 64'(monEntry.hi));
          checkOutput("lo", 64'(lo), 64'(monEntry.lo));
          checkOutput("divZero", 64'(div_zero), 64'(monEntry.dz));
          checkOutput("latency", 64'(monCycles), 64'(monEntry.lat));
        end
        monCycles = 0;
      end
    end
  end

  // Holds the start request until the sequencer is idle, checking stall meanwhile.
  task automatic applyStimulus(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    bit accepted;
    accepted   = 1'b0;
    op_a       = a;
    op_b       = b;
    start_mult = m;
    start_div  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        accepted = 1'b1;
        checkOutput("stallIdle", 64'(stall), 64'd0);
        break;
      end
      checkOutput("stallBusy", 64'(stall), 64'd1);
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL acceptTimeout: got busy=%0b expected idle", busy);
    end else begin
      expQ.push_back(model(m, a, b));
    end
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      total++;
      bad++;
      $display("[TB] FAIL idleTimeout: got busy=%0b expected 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ExpEntry     e;
    bit          done;
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;

    rst        = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = 32'd0;
    op_b       = 32'd0;
    read_hi    = 1'b0;
    read_lo    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_hi = 1'b1;
    read_lo = 1'b1;
    @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstStall", 64'(stall), 64'd0);
    checkOutput("rstHi", 64'(hi), 64'd0);
    checkOutput("rstLo", 64'(lo), 64'd0);
    checkOutput("rstDivZero", 64'(div_zero), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    read_hi = 1'b0;
    read_lo = 1'b0;

    applyStimulus(1, 0, 32'd7, 32'hFFFF_FFFD);
    waitIdle();
    applyStimulus(0, 1, 32'hFFFF_FFEF, 32'd5);
    waitIdle();
    applyStimulus(0, 1, 32'd42, 32'd0);
    waitIdle();
    applyStimulus(1, 0, 32'd3, 32'd5);
    waitIdle();
    applyStimulus(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 32'h8000_0000, 32'h8000_0000);
    applyStimulus(0, 1, 32'hFFFF_FFF9, 32'd0);
    applyStimulus(1, 0, 32'h1234_5678, 32'd0);
    waitIdle();

    // MFHI arriving mid-divide must stall until the new HI is visible.
    applyStimulus(0, 1, 32'hFFFF_FF9C, 32'd7);
    e = model(0, 32'hFFFF_FF9C, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    read_hi = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) begin
        checkOutput("mfhiStall", 64'(stall), 64'd1);
      end else begin
        checkOutput("mfhiRelease", 64'(stall), 64'd0);
        checkOutput("mfhiValue", 64'(hi), 64'(e.hi));
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL mfhiTimeout: got busy=%0b expected 0", busy);
    end
    @(posedge clk);
    #1;
    read_hi = 1'b0;

    // Reset in the middle of a multiply discards it.
    applyStimulus(1, 0, 32'h1234, 32'h10);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortHi", 64'(hi), 64'd0);
    checkOutput("abortLo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 32'h1234, 32'h10);
    waitIdle();

    for (int n = 0; n < 30; n++) begin
      m = 1'($urandom_range(0, 1));
      d = ~m | ($urandom_range(0, 7) == 0);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(0, 15);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      applyStimulus(m, d, a, b);
      if ($urandom_range(0, 1) == 0) begin
        waitIdle();
      end
    end
    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
